// File: rtl/fir_filter_engine.sv
// Offline TAPS-tap FIR pass: streams the original-sound RAM through a Q2.14 filter
// and writes saturated unsigned results to the filtered-sound RAM at the same address.
module fir_filter_engine #(
    parameter int unsigned TAPS   = 16,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned LEN    = 65536
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [15:0]              coef_din,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic [15:0]              rd_data,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [15:0]              wr_data
);

    localparam int unsigned KW    = $clog2(TAPS);
    localparam int unsigned ACC_W = 33 + KW;

    typedef enum logic [2:0] {
        IDLE, FETCH, WAIT, SHIFT, MAC, WRITE, DONE
    } state_t;

    state_t state, state_next;

    logic        [15:0]       dl [TAPS];
    logic signed [15:0]       h  [TAPS];
    logic        [KW-1:0]     k;
    logic        [ADDR_W-1:0] n;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [16:0]       x_ext;
    logic signed [32:0]       prod;
    logic        [15:0]       sat_val;
    logic                     last_tap;
    logic                     last_sample;

    assign last_tap    = (k == KW'(TAPS - 1));
    assign last_sample = (n == ADDR_W'(LEN - 1));
    assign busy        = (state != IDLE) && (state != DONE);
    assign done        = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = FETCH;
            FETCH:   state_next = WAIT;
            WAIT:    state_next = SHIFT;
            SHIFT:   state_next = MAC;
            MAC:     if (last_tap) state_next = WRITE;
            WRITE:   state_next = last_sample ? DONE : FETCH;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        x_ext    = {1'b0, dl[k]};
        prod     = 33'(x_ext) * 33'(h[k]);
        acc_next = acc + ACC_W'(prod);
        shifted  = acc_next >>> 14;
        sat_val  = shifted[15:0];
        if (shifted[ACC_W-1])
            sat_val = '0;
        else if (|shifted[ACC_W-2:16])
            sat_val = '1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < TAPS; i++) begin
                dl[i] <= '0;
                h[i]  <= (i == 0) ? 16'sh4000 : '0;
            end
            k       <= '0;
            n       <= '0;
            acc     <= '0;
            rd_addr <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (coef_we) h[coef_addr] <= coef_din;
                    if (start) begin
                        for (int unsigned i = 0; i < TAPS; i++) dl[i] <= '0;
                        n <= '0;
                    end
                end
                FETCH: rd_addr <= n;
                SHIFT: begin
                    for (int unsigned i = TAPS - 1; i > 0; i--) dl[i] <= dl[i-1];
                    dl[0] <= rd_data;
                    acc   <= '0;
                    k     <= '0;
                end
                MAC: begin
                    acc <= acc_next;
                    k   <= k + KW'(1);
                    // Result is registered on the final MAC edge so it is presented during WRITE
                    if (last_tap) begin
                        wr_en   <= 1'b1;
                        wr_addr <= n;
                        wr_data <= sat_val;
                    end
                end
                WRITE: if (!last_sample) n <= n + ADDR_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_filter_engine.sv
// Self-checking bench for fir_filter_engine: RAM models plus a direct-sum FIR reference.
module tb_fir_filter_engine;

    localparam int TAPS   = 16;
    localparam int ADDR_W = 8;
    localparam int LEN    = 24;
    localparam int CPS    = TAPS + 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              coef_we = 1'b0;
    logic [3:0]        coef_addr = '0;
    logic [15:0]       coef_din = '0;
    logic [15:0]       rd_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic              busy, done, wr_en;
    logic [15:0]       wr_data;

    fir_filter_engine #(.TAPS(TAPS), .ADDR_W(ADDR_W), .LEN(LEN)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_din(coef_din),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        [15:0] orig [256];
    logic signed [15:0] hm   [TAPS];

    always @(posedge clk) rd_data <= orig[rd_addr];

    int total = 0;
    int bad   = 0;

    int w_cyc[$];
    int w_addr[$];
    int w_data[$];
    int d_cyc[$];
    int saved[$];
    int busy_cnt;
    bit timed_out;
    logic post_busy, post_done, post_wr_en;
    logic [ADDR_W-1:0] post_rd_addr, post_wr_addr;
    logic [15:0] post_wr_data;

    function automatic int model_y(int n);
        longint acc = 0;
        for (int kk = 0; kk < TAPS; kk++)
            if (n - kk >= 0) acc += longint'(hm[kk]) * longint'(orig[n-kk]);
        acc = acc >>> 14;
        if (acc < 0) return 0;
        if (acc > 65535) return 65535;
        return int'(acc);
    endfunction

    task automatic write_coef(input int kk, input logic [15:0] v);
        @(negedge clk);
        coef_we = 1'b1; coef_addr = 4'(kk); coef_din = v;
        @(negedge clk);
        coef_we = 1'b0;
        hm[kk] = v;
    endtask

    // Cycle 0 is the cycle in which start is high; all recorded cycles are relative to it.
    task automatic run_pass(input int stray1, input int stray2, input int coef_cyc, input int rst_cyc);
        int s0, rel;
        bit fin;
        w_cyc.delete(); w_addr.delete(); w_data.delete(); d_cyc.delete();
        busy_cnt = 0;
        fin = 1'b0;
        @(negedge clk);
        start = 1'b1;
        s0 = cyc;
        for (int it = 0; it < LEN * CPS + 200; it++) begin
            @(negedge clk);
            rel = cyc - s0;
            if (wr_en) begin
                w_cyc.push_back(rel); w_addr.push_back(int'(wr_addr)); w_data.push_back(int'(wr_data));
            end
            if (done) d_cyc.push_back(rel);
            if (busy) busy_cnt++;
            if (rel == rst_cyc + 1) begin
                post_busy = busy; post_done = done; post_wr_en = wr_en;
                post_rd_addr = rd_addr; post_wr_addr = wr_addr; post_wr_data = wr_data;
            end
            start   = (rel == stray1) || (rel == stray2);
            coef_we = (rel == coef_cyc);
            rst     = (rel != rst_cyc);
            if (rst_cyc >= 0) begin
                if (rel >= rst_cyc + 100) begin fin = 1'b1; break; end
            end else if (d_cyc.size() > 0) begin
                fin = 1'b1; break;
            end
        end
        start = 1'b0; coef_we = 1'b0; rst = 1'b1;
        timed_out = !fin;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < TAPS; i++) hm[i] = (i == 0) ? 16'sh4000 : 16'sh0000;
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0)    begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (wr_en !== 1'b0)   begin bad++; $display("FAIL reset_wr_en got=%b want=0", wr_en); end
        total++; if (rd_addr !== '0)   begin bad++; $display("FAIL reset_rd_addr got=%0h want=0", rd_addr); end
        total++; if (wr_addr !== '0)   begin bad++; $display("FAIL reset_wr_addr got=%0h want=0", wr_addr); end
        total++; if (wr_data !== '0)   begin bad++; $display("FAIL reset_wr_data got=%0h want=0", wr_data); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_passthrough;
        for (int i = 0; i < LEN; i++) orig[i] = 16'(37 * i);
        run_pass(-1, -1, -1, -1);
        total++; if (timed_out) begin bad++; $display("FAIL pass_timeout got=timeout want=done"); end
        total++; if (w_addr.size() != LEN) begin bad++; $display("FAIL pass_wr_count got=%0d want=%0d", w_addr.size(), LEN); end
        for (int i = 0; i < w_addr.size(); i++) begin
            total++;
            if (w_data[i] !== 37 * i || w_addr[i] !== i || w_cyc[i] !== (i + 1) * CPS) begin
                bad++;
                $display("FAIL pass_sample%0d got=(d%0d a%0d c%0d) want=(d%0d a%0d c%0d)",
                         i, w_data[i], w_addr[i], w_cyc[i], 37 * i, i, (i + 1) * CPS);
            end
        end
        total++;
        if (d_cyc.size() != 1 || d_cyc[0] != 1 + LEN * CPS) begin
            bad++; $display("FAIL pass_done_cycle got=%0d pulses want=1 at %0d", d_cyc.size(), 1 + LEN * CPS);
        end
        total++; if (busy_cnt != LEN * CPS) begin bad++; $display("FAIL pass_busy_cycles got=%0d want=%0d", busy_cnt, LEN * CPS); end
    endtask

    task automatic test_impulse;
        for (int i = 0; i < LEN; i++) orig[i] = (i == 0) ? 16'd256 : 16'd0;
        for (int kk = 0; kk < TAPS; kk++) write_coef(kk, 16'(64 * kk));
        run_pass(-1, -1, -1, -1);
        total++; if (timed_out || w_addr.size() != LEN) begin bad++; $display("FAIL imp_count got=%0d want=%0d", w_addr.size(), LEN); end
        for (int i = 0; i < w_addr.size(); i++) begin
            total++;
            if (w_data[i] !== ((i < 16) ? i : 0) || w_addr[i] !== i) begin
                bad++; $display("FAIL imp_sample%0d got=(d%0d a%0d) want=(d%0d a%0d)", i, w_data[i], w_addr[i], (i < 16) ? i : 0, i);
            end
        end
    endtask

    task automatic test_random;
        for (int p = 0; p < 3; p++) begin
            for (int kk = 0; kk < TAPS; kk++)
                write_coef(kk, (p == 0) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 4095) - 2048));
            for (int i = 0; i < LEN; i++) orig[i] = 16'($urandom_range(0, 65535));
            run_pass(-1, -1, -1, -1);
            total++; if (timed_out || w_addr.size() != LEN) begin bad++; $display("FAIL rnd%0d_count got=%0d want=%0d", p, w_addr.size(), LEN); end
            for (int i = 0; i < w_addr.size(); i++) begin
                total++;
                if (w_data[i] !== model_y(i) || w_addr[i] !== i) begin
                    bad++; $display("FAIL rnd%0d_sample%0d got=(d%0d a%0d) want=(d%0d a%0d)", p, i, w_data[i], w_addr[i], model_y(i), i);
                end
            end
        end
    endtask

    task automatic test_saturation;
        int want;
        for (int c = 0; c < 3; c++) begin
            for (int kk = 0; kk < TAPS; kk++)
                case (c)
                    0: write_coef(kk, 16'h4000);
                    1: write_coef(kk, (kk == 0) ? 16'hC000 : 16'h0000);
                    default: write_coef(kk, (kk == 0) ? 16'h0001 : 16'h0000);
                endcase
            for (int i = 0; i < LEN; i++) orig[i] = (c == 0) ? 16'd65535 : (c == 1) ? 16'd1000 : 16'd1;
            want = (c == 0) ? 65535 : 0;
            run_pass(-1, -1, -1, -1);
            total++; if (timed_out || w_addr.size() != LEN) begin bad++; $display("FAIL sat%0d_count got=%0d want=%0d", c, w_addr.size(), LEN); end
            for (int i = 0; i < w_addr.size(); i++) begin
                total++;
                if (w_data[i] !== want) begin bad++; $display("FAIL sat%0d_sample%0d got=%0d want=%0d", c, i, w_data[i], want); end
            end
        end
    endtask

    task automatic test_back_to_back;
        for (int kk = 0; kk < TAPS; kk++) write_coef(kk, 16'($urandom_range(0, 8191) - 4096));
        for (int i = 0; i < LEN; i++) orig[i] = 16'($urandom_range(0, 65535));
        coef_addr = 4'd0; coef_din = 16'h7FFF;
        run_pass(5, 50, 30, -1);
        total++; if (timed_out || w_addr.size() != LEN) begin bad++; $display("FAIL hs_count got=%0d want=%0d", w_addr.size(), LEN); end
        total++; if (d_cyc.size() != 1) begin bad++; $display("FAIL hs_done_pulses got=%0d want=1", d_cyc.size()); end
        saved.delete();
        for (int i = 0; i < w_addr.size(); i++) begin
            saved.push_back(w_data[i]);
            total++;
            if (w_data[i] !== model_y(i) || w_addr[i] !== i) begin
                bad++; $display("FAIL hs_sample%0d got=(d%0d a%0d) want=(d%0d a%0d)", i, w_data[i], w_addr[i], model_y(i), i);
            end
        end
        run_pass(-1, -1, -1, -1);
        total++; if (timed_out || w_addr.size() != saved.size()) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", w_addr.size(), saved.size()); end
        for (int i = 0; i < w_addr.size() && i < saved.size(); i++) begin
            total++;
            if (w_data[i] !== saved[i]) begin bad++; $display("FAIL b2b_sample%0d got=%0d want=%0d", i, w_data[i], saved[i]); end
        end
    endtask

    task automatic test_reset_mid;
        for (int kk = 0; kk < TAPS; kk++) write_coef(kk, 16'($urandom_range(0, 8191) - 4096));
        for (int i = 0; i < LEN; i++) orig[i] = 16'($urandom_range(0, 65535));
        run_pass(-1, -1, -1, 3 * CPS + 10);
        total++; if (timed_out) begin bad++; $display("FAIL mid_timeout got=timeout want=finish"); end
        total++; if (post_busy !== 1'b0)  begin bad++; $display("FAIL mid_busy got=%b want=0", post_busy); end
        total++; if (post_wr_en !== 1'b0) begin bad++; $display("FAIL mid_wr_en got=%b want=0", post_wr_en); end
        total++; if (post_done !== 1'b0)  begin bad++; $display("FAIL mid_done got=%b want=0", post_done); end
        total++; if (post_rd_addr !== '0 || post_wr_addr !== '0 || post_wr_data !== '0) begin
            bad++; $display("FAIL mid_regs got=(r%0h a%0h d%0h) want=(0 0 0)", post_rd_addr, post_wr_addr, post_wr_data);
        end
        total++; if (w_addr.size() != 3) begin bad++; $display("FAIL mid_writes got=%0d want=3", w_addr.size()); end
        total++; if (d_cyc.size() != 0) begin bad++; $display("FAIL mid_done_pulses got=%0d want=0", d_cyc.size()); end
        for (int i = 0; i < TAPS; i++) hm[i] = (i == 0) ? 16'sh4000 : 16'sh0000;
        run_pass(-1, -1, -1, -1);
        total++; if (timed_out || w_addr.size() != LEN) begin bad++; $display("FAIL mid_rerun_count got=%0d want=%0d", w_addr.size(), LEN); end
        for (int i = 0; i < w_addr.size(); i++) begin
            total++;
            if (w_addr[i] !== i || w_data[i] !== int'(orig[i]) || w_data[i] !== model_y(i)) begin
                bad++; $display("FAIL mid_rerun%0d got=(d%0d a%0d) want=(d%0d a%0d)", i, w_data[i], w_addr[i], orig[i], i);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) orig[i] = '0;
        test_reset;
        test_passthrough;
        test_impulse;
        test_random;
        test_saturation;
        test_back_to_back;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
